ex_mem_stage: RTL

Pipeline stage between the JOF32 execute ALU and the data-memory stage. It captures the ALU result plus operand/control fields with a valid/ready handshake and a 2-entry skid buffer, so memory back-pressure never drops an instruction. It also resolves BEQ/BNE/J and issues a one-cycle fetch redirect. LW/LB/SW and ALU ops are forwarded to memory; BEQ/BNE/J/NOP retire inside this stage.

---
 rtl/ex_mem_stage_if.sv | 55 +++++
 rtl/ex_mem_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_if.sv
// Handshake bundles around the EX/MEM stage: execute-side input (with fetch redirect
// feedback) and memory-side output.

interface ex_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic [4:0]        ex_opcode;
  logic [DATA_W-1:0] ex_resultado;
  logic [DATA_W-1:0] ex_rs_val;
  logic [DATA_W-1:0] ex_rt_val;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc;
  logic [REG_W-1:0]  ex_rd;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;

  modport master (
    output ex_valid, ex_opcode, ex_resultado, ex_rs_val, ex_rt_val, ex_imm, ex_pc, ex_rd,
    input  ex_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  ex_valid, ex_opcode, ex_resultado, ex_rs_val, ex_rt_val, ex_imm, ex_pc, ex_rd,
    output ex_ready, redirect_valid, redirect_pc
  );
endinterface

interface mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              mem_valid;
  logic              mem_ready;
  logic [4:0]        mem_opcode;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [REG_W-1:0]  mem_rd;
  logic              mem_we;
  logic              mem_re;
  logic              mem_byte;
  logic              mem_reg_write;

  modport master (
    output mem_valid, mem_opcode, mem_addr, mem_wdata, mem_rd, mem_we, mem_re, mem_byte,
           mem_reg_write,
    input  mem_ready
  );
  modport slave (
    input  mem_valid, mem_opcode, mem_addr, mem_wdata, mem_rd, mem_we, mem_re, mem_byte,
           mem_reg_write,
    output mem_ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer and BEQ/BNE/J resolution that
// issues a one-cycle fetch redirect.

module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  ex_if.slave  ex,
  mem_if.master mem
);

  localparam logic [4:0] OpAluMax = 5'b01000;
  localparam logic [4:0] OpBeq    = 5'b01001;
  localparam logic [4:0] OpBne    = 5'b01010;
  localparam logic [4:0] OpLw     = 5'b01011;
  localparam logic [4:0] OpLb     = 5'b01100;
  localparam logic [4:0] OpSw     = 5'b01101;
  localparam logic [4:0] OpJ      = 5'b01110;

  typedef struct packed {
    logic [4:0]        opcode;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic              we;
    logic              re;
    logic              is_byte;
    logic              reg_write;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q;
  entry_t            main_q, skid_q, new_e;
  logic              ex_ready_q;
  logic              redirect_valid_q;
  logic [DATA_W-1:0] redirect_pc_q;
  logic              fwd, accept, fwd_acc, pop, taken;
  logic [DATA_W-1:0] target;

  always_comb begin
    fwd           = (ex.ex_opcode <= OpAluMax) ||
                    (ex.ex_opcode >= OpLw && ex.ex_opcode <= OpSw);
    accept        = ex.ex_valid && ex_ready_q && !flush;
    fwd_acc       = accept && fwd;
    pop           = (state_q != StEmpty) && mem.mem_ready;

    new_e.opcode    = ex.ex_opcode;
    new_e.addr      = ex.ex_resultado;
    new_e.wdata     = ex.ex_rt_val;
    new_e.rd        = ex.ex_rd;
    new_e.we        = (ex.ex_opcode == OpSw);
    new_e.re        = (ex.ex_opcode == OpLw) || (ex.ex_opcode == OpLb);
    new_e.is_byte   = (ex.ex_opcode == OpLb);
    new_e.reg_write = (ex.ex_opcode <= OpAluMax) || new_e.re;

    taken = 1'b0;
    case (ex.ex_opcode)
      OpBeq:   taken = (ex.ex_rs_val == ex.ex_rt_val);
      OpBne:   taken = (ex.ex_rs_val != ex.ex_rt_val);
      OpJ:     taken = 1'b1;
      default: taken = 1'b0;
    endcase
    // Branch offset is in words; the sum wraps modulo 2^DATA_W.
    target = (ex.ex_opcode == OpJ) ? ex.ex_imm
                                   : ex.ex_pc + DATA_W'(4) + (ex.ex_imm << 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StEmpty;
      main_q           <= '0;
      skid_q           <= '0;
      ex_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      if (flush) begin
        state_q    <= StEmpty;
        skid_q     <= '0;
        ex_ready_q <= 1'b1;
      end else begin
        if (accept && taken) begin
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= target;
        end
        case (state_q)
          StEmpty: begin
            if (fwd_acc) begin
              main_q  <= new_e;
              state_q <= StOne;
            end
          end
          StOne: begin
            if (fwd_acc && pop) begin
              main_q <= new_e;
            end else if (fwd_acc) begin
              skid_q     <= new_e;
              state_q    <= StTwo;
              ex_ready_q <= 1'b0;
            end else if (pop) begin
              state_q <= StEmpty;
            end
          end
          StTwo: begin
            if (pop) begin
              main_q     <= skid_q;
              skid_q     <= '0;
              state_q    <= StOne;
              ex_ready_q <= 1'b1;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  assign ex.ex_ready       = ex_ready_q;
  assign ex.redirect_valid = redirect_valid_q;
  assign ex.redirect_pc    = redirect_pc_q;

  assign mem.mem_valid     = (state_q != StEmpty);
  assign mem.mem_opcode    = main_q.opcode;
  assign mem.mem_addr      = main_q.addr;
  assign mem.mem_wdata     = main_q.wdata;
  assign mem.mem_rd        = main_q.rd;
  assign mem.mem_we        = main_q.we;
  assign mem.mem_re        = main_q.re;
  assign mem.mem_byte      = main_q.is_byte;
  assign mem.mem_reg_write = main_q.reg_write;

endmodule
